farm_vehicle_sensor: RTL and testbench

- Conditions the raw farm-road loop-detector input and tracks how many vehicles are waiting.
- Drives the car-request input `x` of the highway/farm traffic-light controller.
- Observes the controller's 2-bit farm light code to retire vehicles while the farm light is green.
- This is the producer side of the controller's `x` interface and the consumer of its farm output.

---
 rtl/farm_vehicle_sensor.sv | 152 +++++++++++++++
 tb/tb_farm_vehicle_sensor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/farm_vehicle_sensor.sv
// rtl/farm_vehicle_sensor.sv - farm-road vehicle detector and waiting-queue tracker
// Feeds the traffic-light controller car request x and retires vehicles during farm GREEN.
module farm_vehicle_sensor #(
   parameter int SYNC_STAGES   = 2,
   parameter int DEBOUNCE      = 4,
   parameter int CNT_W         = 4,
   parameter int DEPART_CYCLES = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             raw_sensor,
   input  logic [1:0]       farm,
   output logic             x,
   output logic [CNT_W-1:0] queue_count,
   output logic             arrival,
   output logic             overflow,
   output logic             fault
);

   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int DT_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DEPART_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] FARM_GREEN   = 2'd2;
   localparam logic [1:0] FARM_ILLEGAL = 2'd3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_QUEUED  = 2'd1;
   localparam logic [1:0] ST_SERVING = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   filt_q, filt_d;
   logic                   filt_prev_q, filt_prev_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   arrival_q, arrival_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DT_W-1:0]        tmr_q, tmr_d;
   logic [1:0]             state_q, state_d;
   logic                   x_q, x_d;
   logic                   overflow_q, overflow_d;
   logic                   fault_q, fault_d;

   logic s;
   logic serving;
   logic depart;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_sensor};
   end

   // Filtered level only follows s after DEBOUNCE consecutive disagreeing cycles.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (s != filt_q) begin
         if (db_cnt_q == DB_LAST) begin
            filt_d   = s;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      filt_prev_d = filt_q;
      arrival_d   = filt_q & ~filt_prev_q;
   end

   // Serving is judged on the current count and the farm code sampled this cycle.
   always_comb begin
      serving = (state_q != ST_IDLE) && (farm == FARM_GREEN);
      depart  = 1'b0;
      tmr_d   = '0;
      if (serving) begin
         if (tmr_q == DT_LAST) begin
            depart = 1'b1;
            tmr_d  = '0;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      case ({arrival_q, depart})
         2'b10: begin
            if (cnt_q == CNT_MAX) begin
               overflow_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      fault_d = fault_q | (farm == FARM_ILLEGAL);
      x_d     = (cnt_d != '0) && !fault_d;
      if (cnt_d == '0) begin
         state_d = ST_IDLE;
      end else if (farm == FARM_GREEN) begin
         state_d = ST_SERVING;
      end else begin
         state_d = ST_QUEUED;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sync_q      <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         db_cnt_q    <= '0;
         arrival_q   <= 1'b0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         state_q     <= ST_IDLE;
         x_q         <= 1'b0;
         overflow_q  <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         db_cnt_q    <= db_cnt_d;
         arrival_q   <= arrival_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         state_q     <= state_d;
         x_q         <= x_d;
         overflow_q  <= overflow_d;
         fault_q     <= fault_d;
      end
   end

   assign x           = x_q;
   assign queue_count = cnt_q;
   assign arrival     = arrival_q;
   assign overflow    = overflow_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_farm_vehicle_sensor.sv
// tb/tb_farm_vehicle_sensor.sv - scoreboard bench for farm_vehicle_sensor
module tb_farm_vehicle_sensor;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       raw_sensor = 1'b0;
   logic [1:0] farm = 2'd0;
   logic       x;
   logic [3:0] queue_count;
   logic       arrival;
   logic       overflow;
   logic       fault;

   farm_vehicle_sensor #(
      .SYNC_STAGES(2),
      .DEBOUNCE(4),
      .CNT_W(4),
      .DEPART_CYCLES(3)
   ) dut (
      .clk(clk),
      .clear(clear),
      .raw_sensor(raw_sensor),
      .farm(farm),
      .x(x),
      .queue_count(queue_count),
      .arrival(arrival),
      .overflow(overflow),
      .fault(fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      int    c;
      string name;
      logic  x;
      int    cnt;
      logic  ov;
      logic  flt;
   } exp_t;

   exp_t chk_q[$];
   int   arr_q[$];
   exp_t mon_e;
   int   mon_a;

   task automatic expect_at(input int c, input string name, input int cnt,
                            input logic ov, input logic flt);
      exp_t e;
      e.c    = c;
      e.name = name;
      e.cnt  = cnt;
      e.ov   = ov;
      e.flt  = flt;
      e.x    = (cnt != 0) && !flt;
      chk_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: consumes expectations as their cycle comes up and every arrival pulse.
   always @(negedge clk) begin
      while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
         mon_e = chk_q.pop_front();
         total++;
         if (mon_e.c != cyc || x !== mon_e.x || queue_count !== 4'(mon_e.cnt) ||
             overflow !== mon_e.ov || fault !== mon_e.flt) begin
            bad++;
            $display("FAIL %s cyc=%0d want_cyc=%0d got x=%b cnt=%0d ov=%b flt=%b want x=%b cnt=%0d ov=%b flt=%b",
                     mon_e.name, cyc, mon_e.c, x, queue_count, overflow, fault,
                     mon_e.x, mon_e.cnt, mon_e.ov, mon_e.flt);
         end
      end
      if (arrival === 1'b1) begin
         total++;
         if (arr_q.size() == 0) begin
            bad++;
            $display("FAIL arrival_unexpected cyc=%0d got pulse want none", cyc);
         end else begin
            mon_a = arr_q.pop_front();
            if (mon_a != cyc) begin
               bad++;
               $display("FAIL arrival_time got cyc=%0d want cyc=%0d", cyc, mon_a);
            end
         end
      end else if (arr_q.size() > 0 && arr_q[0] < cyc) begin
         mon_a = arr_q.pop_front();
         total++;
         bad++;
         $display("FAIL arrival_missing cyc=%0d want pulse at cyc=%0d got arrival=%b", cyc, mon_a, arrival);
      end
   end

   always @(posedge clear) begin
      #1;
      total++;
      if ({x, queue_count, arrival, overflow, fault} !== 8'h00) begin
         bad++;
         $display("FAIL async_clear got x=%b cnt=%0d arr=%b ov=%b flt=%b want all 0",
                  x, queue_count, arrival, overflow, fault);
      end
   end

   task automatic do_reset();
      clear = 1'b1;
      step(2);
      clear = 1'b0;
      expect_at(cyc + 1, "post_reset", 0, 1'b0, 1'b0);
      step(2);
   endtask

   task automatic pulse(input int cnt_after, input logic ov_after);
      int b;
      b = cyc;
      raw_sensor = 1'b1;
      arr_q.push_back(b + 7);
      expect_at(b + 8, "pulse_cnt", cnt_after, ov_after, 1'b0);
      step(8);
      raw_sensor = 1'b0;
      step(8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      step(1);
      do_reset();

      // Latency of a held sensor, then a short dropout that must not re-trigger.
      b = cyc;
      raw_sensor = 1'b1;
      arr_q.push_back(b + 7);
      expect_at(b + 6, "t1_pre", 0, 1'b0, 1'b0);
      expect_at(b + 7, "t1_arr", 0, 1'b0, 1'b0);
      expect_at(b + 8, "t1_cnt", 1, 1'b0, 1'b0);
      step(10);
      raw_sensor = 1'b0;
      step(3);
      raw_sensor = 1'b1;
      step(3);
      expect_at(cyc + 6, "t1_glitch", 1, 1'b0, 1'b0);
      step(8);
      raw_sensor = 1'b0;
      step(12);
      do_reset();

      // Three arrivals, then drain under GREEN.
      pulse(1, 1'b0);
      pulse(2, 1'b0);
      pulse(3, 1'b0);
      b = cyc;
      farm = 2'd2;
      expect_at(b + 1, "t2_hold", 3, 1'b0, 1'b0);
      expect_at(b + 3, "t2_dep1", 2, 1'b0, 1'b0);
      expect_at(b + 5, "t2_mid", 2, 1'b0, 1'b0);
      expect_at(b + 6, "t2_dep2", 1, 1'b0, 1'b0);
      expect_at(b + 8, "t2_last1", 1, 1'b0, 1'b0);
      expect_at(b + 9, "t2_empty", 0, 1'b0, 1'b0);
      step(12);
      farm = 2'd0;
      do_reset();

      // YELLOW interruption discards partial depart progress.
      pulse(1, 1'b0);
      pulse(2, 1'b0);
      b = cyc;
      farm = 2'd2;
      expect_at(b + 1, "t3_g1", 2, 1'b0, 1'b0);
      expect_at(b + 2, "t3_g2", 2, 1'b0, 1'b0);
      expect_at(b + 3, "t3_yellow", 2, 1'b0, 1'b0);
      expect_at(b + 4, "t3_r1", 2, 1'b0, 1'b0);
      expect_at(b + 5, "t3_r2", 2, 1'b0, 1'b0);
      expect_at(b + 6, "t3_resume", 1, 1'b0, 1'b0);
      expect_at(b + 9, "t3_empty", 0, 1'b0, 1'b0);
      step(2);
      farm = 2'd1;
      step(1);
      farm = 2'd2;
      step(8);
      farm = 2'd0;
      do_reset();

      // Arrival and departure on the same edge cancel.
      pulse(1, 1'b0);
      b = cyc;
      raw_sensor = 1'b1;
      arr_q.push_back(b + 7);
      expect_at(b + 7, "t4_before", 1, 1'b0, 1'b0);
      expect_at(b + 8, "t4_coincide", 1, 1'b0, 1'b0);
      expect_at(b + 9, "t4_after1", 1, 1'b0, 1'b0);
      expect_at(b + 11, "t4_empty", 0, 1'b0, 1'b0);
      step(5);
      farm = 2'd2;
      step(3);
      raw_sensor = 1'b0;
      step(6);
      farm = 2'd0;
      step(8);
      do_reset();

      // Saturation and sticky overflow.
      for (int i = 1; i <= 15; i++) pulse(i, 1'b0);
      pulse(15, 1'b1);
      b = cyc;
      farm = 2'd2;
      expect_at(b + 3, "t5_dep1", 14, 1'b1, 1'b0);
      expect_at(b + 6, "t5_dep2", 13, 1'b1, 1'b0);
      step(8);
      farm = 2'd0;
      do_reset();

      // Illegal farm code, then asynchronous clear mid-cycle and re-detection.
      pulse(1, 1'b0);
      pulse(2, 1'b0);
      b = cyc;
      farm = 2'd3;
      expect_at(b + 1, "t6_fault", 2, 1'b0, 1'b1);
      expect_at(b + 3, "t6_fault_hold", 2, 1'b0, 1'b1);
      step(1);
      farm = 2'd0;
      step(4);
      raw_sensor = 1'b1;
      #2;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      b = cyc;
      arr_q.push_back(b + 7);
      expect_at(b + 8, "t6_redetect", 1, 1'b0, 1'b0);
      step(12);
      raw_sensor = 1'b0;
      step(12);

      for (int i = 0; i < 100 && (chk_q.size() > 0 || arr_q.size() > 0); i++) step(1);
      while (chk_q.size() > 0) begin
         mon_e = chk_q.pop_front();
         total++;
         bad++;
         $display("FAIL %s never_checked want_cyc=%0d", mon_e.name, mon_e.c);
      end
      while (arr_q.size() > 0) begin
         mon_a = arr_q.pop_front();
         total++;
         bad++;
         $display("FAIL arrival_missing_end want cyc=%0d got none", mon_a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
